// File: rtl/lights_pkg.sv
// lights_pkg: shared encodings, command characters and FSM states for the LED show.
package lights_pkg;
  localparam int NUM_LEDS = 24;
  localparam int INT_W = 3;
  localparam int PAT_W = NUM_LEDS * INT_W;
  localparam logic [1:0] MODE_RANDOM = 2'd0;
  localparam logic [1:0] MODE_STORED = 2'd1;
  localparam logic [1:0] MODE_USER = 2'd2;
  localparam logic [7:0] CMD_LOAD = 8'h70;
  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_LEND = 8'h6c;
  localparam logic [7:0] CMD_USER = 8'h75;
  localparam logic [7:0] CMD_RANDOM = 8'h72;
  localparam logic [7:0] CMD_STORED = 8'h73;
  localparam logic [7:0] CMD_INT = 8'h69;
  localparam logic [7:0] CMD_AUTO = 8'h61;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WADDR, ST_LEND, ST_WRITE} state_e;
endpackage

// File: rtl/switch_timer.sv
// switch_timer: counts ticks and pulses toggle on every SWITCH_TICKS-th tick; clr restarts it.
module switch_timer #(
  parameter int SWITCH_TICKS = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic toggle
);
  localparam int CW = SWITCH_TICKS > 1 ? $clog2(SWITCH_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SWITCH_TICKS - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign toggle = tick & ~clr & (cnt_q == LAST);
  always_comb cnt_d = clr ? '0 : !tick ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/show_scheduler.sv
// show_scheduler: UART command decoder, source-mode sequencer and pattern-RAM port arbiter.
// Define SHOW_SCHEDULER_TIMEOUT_EN to abort partial commands after TIMEOUT_CYCLES idle cycles.
module show_scheduler
  import lights_pkg::*;
#(
  parameter int SWITCH_TICKS = 256,
  parameter int TIMEOUT_CYCLES = 1474560
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_byte,
  input  logic             tick,
  output logic [1:0]       mode,
  output logic [PAT_W-1:0] user_int,
  output logic [7:0]       ram_addr,
  output logic [PAT_W-1:0] ram_wdata,
  output logic             ram_we,
  output logic             busy
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] stage_q, stage_d, user_q, user_d;
  logic [7:0] waddr_q, waddr_d, loop_q, loop_d, play_q, play_d;
  logic [1:0] mode_q, mode_d;
  logic auto_q, auto_d, pend_q, pend_d;
  logic idle_cmd, clr, toggle, timeout, adv;

  assign idle_cmd = cmd_valid && state_q == ST_IDLE;
  assign clr = idle_cmd && (cmd_byte == CMD_RANDOM || cmd_byte == CMD_STORED ||
                            cmd_byte == CMD_INT || cmd_byte == CMD_AUTO);

  switch_timer #(.SWITCH_TICKS(SWITCH_TICKS)) u_timer (
    .clk(clk), .rst(rst), .clr(clr), .tick(tick), .toggle(toggle)
  );

`ifdef SHOW_SCHEDULER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q;
  assign timeout = state_q != ST_IDLE && !cmd_valid && idle_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) idle_q <= '0;
    else idle_q <= (cmd_valid || state_q == ST_IDLE) ? '0 : idle_q + TW'(1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stage_d = stage_q;
    waddr_d = waddr_q;
    loop_d = loop_q;
    user_d = user_q;
    if (state_q == ST_WRITE || timeout) state_d = ST_IDLE;
    else if (cmd_valid)
      case (state_q)
        ST_IDLE: begin
          state_d = cmd_byte == CMD_LOAD ? ST_LOAD : cmd_byte == CMD_WRITE ? ST_WADDR :
                    cmd_byte == CMD_LEND ? ST_LEND : ST_IDLE;
          cnt_d = cmd_byte == CMD_LOAD ? 4'd0 : cnt_q;
          user_d = cmd_byte == CMD_USER ? stage_q : user_q;
        end
        ST_LOAD: begin
          stage_d = {stage_q[PAT_W-9:0], cmd_byte};
          cnt_d = cnt_q + 4'd1;
          state_d = cnt_q == 4'd8 ? ST_IDLE : ST_LOAD;
        end
        ST_WADDR: begin
          waddr_d = cmd_byte;
          state_d = ST_WRITE;
        end
        ST_LEND: begin
          loop_d = cmd_byte;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
  end

  always_comb begin
    mode_d = mode_q;
    auto_d = auto_q;
    if (clr) begin
      auto_d = cmd_byte == CMD_AUTO;
      mode_d = cmd_byte == CMD_STORED ? MODE_STORED : cmd_byte == CMD_INT ? MODE_USER : MODE_RANDOM;
    end else if (auto_q && toggle) mode_d = mode_q == MODE_RANDOM ? MODE_STORED : MODE_RANDOM;
  end

  // A tick landing on the write cycle is deferred one cycle rather than dropped.
  assign ram_we = state_q == ST_WRITE;
  assign adv = (tick | pend_q) & ~ram_we;
  assign pend_d = ram_we & tick;
  assign play_d = !adv ? play_q : (play_q >= loop_q) ? 8'd0 : play_q + 8'd1;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      stage_q <= '0;
      user_q <= '0;
      waddr_q <= '0;
      loop_q <= 8'd255;
      play_q <= '0;
      mode_q <= MODE_RANDOM;
      auto_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stage_q <= stage_d;
      user_q <= user_d;
      waddr_q <= waddr_d;
      loop_q <= loop_d;
      play_q <= play_d;
      mode_q <= mode_d;
      auto_q <= auto_d;
      pend_q <= pend_d;
    end

  assign mode = mode_q;
  assign user_int = user_q;
  assign ram_wdata = stage_q;
  assign ram_addr = ram_we ? waddr_q : play_q;
  assign busy = state_q != ST_IDLE;
endmodule
